mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/soc_bus_pkg.sv | 20 ++
 rtl/rr_arbiter2.sv | 34 +++
 rtl/mem_bus_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_bus_pkg.sv
// Shared SoC bus constants: default widths, owner encoding and arbiter state type.
package soc_bus_pkg;

  localparam int unsigned BUS_DATA_W = 32;
  localparam int unsigned BUS_ADDR_W = 32;
  localparam int unsigned OWNER_W    = 2;
  localparam int unsigned HOLD_W     = 8;

  localparam logic [OWNER_W-1:0] OWNER_IDLE = 2'd0;
  localparam logic [OWNER_W-1:0] OWNER_M0   = 2'd1;
  localparam logic [OWNER_W-1:0] OWNER_M1   = 2'd2;

  // Owner of the previous cycle, as seen by the arbiter.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin grant decision with optional lock-and-hold override.
module rr_arbiter2
  import soc_bus_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic [1:0]        i_req,
  input  logic              i_last,
  input  logic [1:0]        i_prev,
  input  logic [1:0]        i_lock,
  input  logic [HOLD_W-1:0] i_hold_cnt,
  output logic [1:0]        o_gnt
);

  logic w_hold_ok;

  always_comb begin
    o_gnt     = 2'b00;
    w_hold_ok = (i_hold_cnt < HOLD_W'(MAX_HOLD));
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11: begin
        // A locked previous owner keeps the bus until its hold budget runs out.
        if (i_prev[0] && i_lock[0] && w_hold_ok)      o_gnt = 2'b01;
        else if (i_prev[1] && i_lock[1] && w_hold_ok) o_gnt = 2'b10;
        else if (i_last)                              o_gnt = 2'b01;
        else                                          o_gnt = 2'b10;
      end
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master single-beat memory bus arbiter with read-return tracking.
// Define MEM_ARB_LOCK_EN to add mN_lock ports and the consecutive-grant hold counter.
module mem_bus_arbiter
  import soc_bus_pkg::*;
#(
  parameter int unsigned DATA_W   = BUS_DATA_W,
  parameter int unsigned ADDR_W   = BUS_ADDR_W,
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               m0_req,
  input  logic               m0_we,
  input  logic [ADDR_W-1:0]  m0_addr,
  input  logic [DATA_W-1:0]  m0_wdata,
  input  logic               m1_req,
  input  logic               m1_we,
  input  logic [ADDR_W-1:0]  m1_addr,
  input  logic [DATA_W-1:0]  m1_wdata,
`ifdef MEM_ARB_LOCK_EN
  input  logic               m0_lock,
  input  logic               m1_lock,
`endif
  output logic               m0_gnt,
  output logic [DATA_W-1:0]  m0_rdata,
  output logic               m0_rvalid,
  output logic               m1_gnt,
  output logic [DATA_W-1:0]  m1_rdata,
  output logic               m1_rvalid,
  output logic [ADDR_W-1:0]  bus_addr,
  output logic               bus_we,
  output logic [DATA_W-1:0]  bus_wdata,
  input  logic [DATA_W-1:0]  bus_rdata,
  output logic [OWNER_W-1:0] owner
);

  arb_state_e        r_state, w_next;
  logic              r_last;
  logic              r_rd_pending;
  logic              r_rd_owner;
  logic [1:0]        w_req;
  logic [1:0]        w_prev;
  logic [1:0]        w_lock;
  logic [HOLD_W-1:0] w_hold;
  logic [1:0]        w_arb_gnt;
  logic [1:0]        w_gnt;
  logic              w_rd_grant;

  assign w_req  = {m1_req, m0_req};
  assign w_prev = {r_state == ST_OWN1, r_state == ST_OWN0};

`ifdef MEM_ARB_LOCK_EN
  logic [HOLD_W-1:0] r_hold;
  logic [HOLD_W-1:0] w_hold_inc;

  assign w_lock     = {m1_lock, m0_lock};
  assign w_hold     = r_hold;
  assign w_hold_inc = (r_hold == {HOLD_W{1'b1}}) ? r_hold : r_hold + HOLD_W'(1);

  // Counts consecutive locked grants to the same owner; restarts on any ownership change.
  always_ff @(posedge clk) begin
    if (!reset)                     r_hold <= '0;
    else if (w_gnt[0] && m0_lock)   r_hold <= (r_state == ST_OWN0) ? w_hold_inc : HOLD_W'(1);
    else if (w_gnt[1] && m1_lock)   r_hold <= (r_state == ST_OWN1) ? w_hold_inc : HOLD_W'(1);
    else                            r_hold <= '0;
  end
`else
  assign w_lock = 2'b00;
  assign w_hold = '0;
`endif

  rr_arbiter2 #(
    .MAX_HOLD (MAX_HOLD)
  ) u_rr_arbiter2 (
    .i_req      (w_req),
    .i_last     (r_last),
    .i_prev     (w_prev),
    .i_lock     (w_lock),
    .i_hold_cnt (w_hold),
    .o_gnt      (w_arb_gnt)
  );

  // Grants are suppressed while reset is held so the bus stays quiet.
  assign w_gnt      = w_arb_gnt & {2{reset}};
  assign m0_gnt     = w_gnt[0];
  assign m1_gnt     = w_gnt[1];
  assign w_rd_grant = (w_gnt[0] && !m0_we) || (w_gnt[1] && !m1_we);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = ST_IDLE;
    owner  = OWNER_IDLE;
    if (w_gnt[0]) begin
      w_next = ST_OWN0;
      owner  = OWNER_M0;
    end else if (w_gnt[1]) begin
      w_next = ST_OWN1;
      owner  = OWNER_M1;
    end
  end

  // Last owner defaults to master 1 so the first tie goes to master 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_last       <= 1'b1;
      r_rd_pending <= 1'b0;
      r_rd_owner   <= 1'b0;
    end else begin
      if (w_gnt[0])      r_last <= 1'b0;
      else if (w_gnt[1]) r_last <= 1'b1;
      r_rd_pending <= w_rd_grant;
      if (w_rd_grant) r_rd_owner <= w_gnt[1];
    end
  end

  always_comb begin
    bus_addr  = '0;
    bus_we    = 1'b0;
    bus_wdata = '0;
    if (w_gnt[0]) begin
      bus_addr  = m0_addr;
      bus_we    = m0_we;
      bus_wdata = m0_wdata;
    end else if (w_gnt[1]) begin
      bus_addr  = m1_addr;
      bus_we    = m1_we;
      bus_wdata = m1_wdata;
    end
  end

  assign m0_rvalid = reset && r_rd_pending && !r_rd_owner;
  assign m1_rvalid = reset && r_rd_pending &&  r_rd_owner;
  assign m0_rdata  = m0_rvalid ? bus_rdata : '0;
  assign m1_rdata  = m1_rvalid ? bus_rdata : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (lock scenario runs when MEM_ARB_LOCK_EN is defined).
module tb_mem_bus_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr, bus_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, bus_wdata, bus_rdata;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, bus_we;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [1:0]    owner;
`ifdef MEM_ARB_LOCK_EN
  logic          m0_lock, m1_lock;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_HOLD(3)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
`ifdef MEM_ARB_LOCK_EN
    .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .bus_addr(bus_addr), .bus_we(bus_we), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .owner(owner)
  );

  task automatic idle_inputs;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    bus_rdata = '0;
`ifdef MEM_ARB_LOCK_EN
    m0_lock = 0; m1_lock = 0;
`endif
  endtask

  task automatic next_cycle;
    @(posedge clk); #1;
  endtask

  task automatic apply_reset;
    reset = 1'b0;
    idle_inputs();
    repeat (2) next_cycle();
    reset = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    idle_inputs();
    next_cycle();
    m0_req = 1; m1_req = 1; m0_addr = 32'h40; m1_addr = 32'h80; m1_we = 1; m1_wdata = 32'h55;
    @(negedge clk);
    n_checks++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, bus_we} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: gnt/rvalid/we=%b required 00000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, bus_we});
    end
    n_checks++;
    if (bus_addr !== '0 || bus_wdata !== '0 || owner !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_bus: addr=%h wdata=%h owner=%0d required 0", bus_addr, bus_wdata, owner);
    end
    next_cycle();
    apply_reset();
  endtask

  task automatic test_single_read;
    m0_req = 1; m0_we = 0; m0_addr = 32'h0001_0004;
    @(negedge clk);
    n_checks++;
    if (m0_gnt !== 1 || m1_gnt !== 0 || owner !== 2'd1 || bus_addr !== 32'h0001_0004 || bus_we !== 0) begin
      n_fail++;
      $display("FAIL single_read_gnt: gnt=%b%b owner=%0d addr=%h we=%b required 10 1 00010004 0",
               m0_gnt, m1_gnt, owner, bus_addr, bus_we);
    end
    next_cycle();
    m0_req = 0; bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_checks++;
    if (m0_rvalid !== 1 || m0_rdata !== 32'hDEAD_BEEF || m1_rvalid !== 0 || m1_rdata !== '0) begin
      n_fail++;
      $display("FAIL single_read_rvalid: m0 %b/%h m1 %b/%h required 1/deadbeef 0/0",
               m0_rvalid, m0_rdata, m1_rvalid, m1_rdata);
    end
    next_cycle();
    bus_rdata = 32'h1111_2222;
    @(negedge clk);
    n_checks++;
    if (m0_rvalid !== 0 || m0_rdata !== '0 || m0_gnt !== 0 || owner !== 2'd0) begin
      n_fail++;
      $display("FAIL single_read_pulse: rvalid=%b rdata=%h gnt=%b owner=%0d required 0 0 0 0",
               m0_rvalid, m0_rdata, m0_gnt, owner);
    end
    next_cycle();
  endtask

  task automatic test_alternate;
    logic [1:0] exp_owner [6];
    exp_owner = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2};
    apply_reset();
    m0_req = 1; m0_we = 1; m0_addr = 32'hA0; m0_wdata = 32'hA;
    m1_req = 1; m1_we = 1; m1_addr = 32'hB0; m1_wdata = 32'hB;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (owner !== exp_owner[i] || m0_gnt !== (exp_owner[i] == 2'd1) || m1_gnt !== (exp_owner[i] == 2'd2) ||
          bus_addr !== ((exp_owner[i] == 2'd1) ? 32'hA0 : 32'hB0)) begin
        n_fail++;
        $display("FAIL alternate[%0d]: owner=%0d gnt=%b%b addr=%h required owner %0d",
                 i, owner, m0_gnt, m1_gnt, bus_addr, exp_owner[i]);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_write_then_read;
    m1_req = 1; m1_we = 1; m1_addr = 32'hF000_0000; m1_wdata = 32'h1;
    @(negedge clk);
    n_checks++;
    if (m1_gnt !== 1 || bus_we !== 1 || bus_addr !== 32'hF000_0000 || bus_wdata !== 32'h1 || owner !== 2'd2) begin
      n_fail++;
      $display("FAIL wr_phase: gnt1=%b we=%b addr=%h wdata=%h owner=%0d required 1 1 f0000000 1 2",
               m1_gnt, bus_we, bus_addr, bus_wdata, owner);
    end
    next_cycle();
    m1_req = 0; m1_we = 0; m0_req = 1; m0_we = 0; m0_addr = 32'h100;
    @(negedge clk);
    n_checks++;
    if (m0_gnt !== 1 || bus_we !== 0 || bus_addr !== 32'h100 || m1_rvalid !== 0 || m0_rvalid !== 0) begin
      n_fail++;
      $display("FAIL rd_after_wr: gnt0=%b we=%b addr=%h rv=%b%b required 1 0 100 00",
               m0_gnt, bus_we, bus_addr, m0_rvalid, m1_rvalid);
    end
    next_cycle();
    m0_req = 0; bus_rdata = 32'h1234_5678;
    @(negedge clk);
    n_checks++;
    if (m0_rvalid !== 1 || m0_rdata !== 32'h1234_5678 || m1_rvalid !== 0) begin
      n_fail++;
      $display("FAIL rd_after_wr_data: m0 %b/%h m1_rvalid=%b required 1/12345678 0",
               m0_rvalid, m0_rdata, m1_rvalid);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_back_to_back;
    // Last owner is master 0 here, so the first tie goes to master 1.
    logic [1:0]    exp_gnt [3];
    logic [1:0]    exp_rv  [3];
    logic [DW-1:0] rd      [3];
    exp_gnt = '{2'b10, 2'b01, 2'b10};
    exp_rv  = '{2'b00, 2'b10, 2'b01};
    rd      = '{32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002};
    m0_req = 1; m0_we = 0; m0_addr = 32'h200;
    m1_req = 1; m1_we = 0; m1_addr = 32'h300;
    for (int i = 0; i < 3; i++) begin
      bus_rdata = rd[i];
      @(negedge clk);
      n_checks++;
      if ({m1_gnt, m0_gnt} !== exp_gnt[i] || {m1_rvalid, m0_rvalid} !== exp_rv[i] ||
          m1_rdata !== (exp_rv[i][1] ? rd[i] : '0) || m0_rdata !== (exp_rv[i][0] ? rd[i] : '0)) begin
        n_fail++;
        $display("FAIL b2b[%0d]: gnt10=%b%b rv10=%b%b rd1=%h rd0=%h required gnt %b rv %b data %h",
                 i, m1_gnt, m0_gnt, m1_rvalid, m0_rvalid, m1_rdata, m0_rdata, exp_gnt[i], exp_rv[i], rd[i]);
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_reset_pending;
    m1_req = 1; m1_we = 0; m1_addr = 32'h400;
    @(negedge clk);
    n_checks++;
    if (m1_gnt !== 1) begin
      n_fail++;
      $display("FAIL rst_pend_gnt: gnt1=%b required 1", m1_gnt);
    end
    next_cycle();
    reset = 1'b0; m1_req = 1; m0_req = 1; bus_rdata = 32'hAAAA_5555;
    @(negedge clk);
    n_checks++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, bus_we} !== 5'b0 || m1_rdata !== '0 ||
        bus_addr !== '0 || owner !== 2'd0) begin
      n_fail++;
      $display("FAIL rst_pend_outputs: ctl=%b rd1=%h addr=%h owner=%0d required 0",
               {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, bus_we}, m1_rdata, bus_addr, owner);
    end
    next_cycle();
    m0_req = 0; m1_req = 0;
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (m0_rvalid !== 0 || m1_rvalid !== 0 || m1_rdata !== '0) begin
      n_fail++;
      $display("FAIL rst_release_rvalid: rv=%b%b rd1=%h required 00 0", m0_rvalid, m1_rvalid, m1_rdata);
    end
    next_cycle();
    // Tie right after reset goes to master 0.
    m0_req = 1; m1_req = 1; m0_we = 1; m1_we = 1;
    @(negedge clk);
    n_checks++;
    if (m0_gnt !== 1 || m1_gnt !== 0) begin
      n_fail++;
      $display("FAIL rst_first_tie: gnt=%b%b required 10", m0_gnt, m1_gnt);
    end
    next_cycle();
    idle_inputs();
  endtask

`ifdef MEM_ARB_LOCK_EN
  task automatic test_lock;
    logic [1:0] exp_owner [8];
    exp_owner = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd1, 2'd2};
    apply_reset();
    m0_req = 1; m0_we = 1; m0_lock = 1;
    m1_req = 1; m1_we = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (owner !== exp_owner[i] || m0_gnt !== (exp_owner[i] == 2'd1)) begin
        n_fail++;
        $display("FAIL lock[%0d]: owner=%0d gnt=%b%b required owner %0d", i, owner, m0_gnt, m1_gnt, exp_owner[i]);
      end
      next_cycle();
    end
    idle_inputs();
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_alternate();
    test_write_then_read();
    test_back_to_back();
    test_reset_pending();
`ifdef MEM_ARB_LOCK_EN
    test_lock();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
